// File: rtl/map_030_flash_emu.sv
`default_nettype none
// ============================================================================
// Module   : map_030_flash_emu
// Desc     : SST39SF040 command-set emulation (program, sector/chip erase,
//            software ID, status polling) on top of the PSRAM backing PRG.
// Revision : 1.0 - initial release
// ============================================================================
module map_030_flash_emu #(
    parameter logic [7:0] ID_MFG = 8'hBF,
    parameter logic [7:0] ID_DEV = 8'hB7,
    parameter int         ADDR_W = 19,
    parameter int         SECT_W = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_stb,
    input  logic              rd_stb,
    input  logic [ADDR_W-1:0] bus_addr,
    input  logic [7:0]        bus_dat,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdat,
    input  logic              mem_ack,
    input  logic [7:0]        mem_rdat,
    output logic              rd_ovr,
    output logic [7:0]        rd_dat,
    output logic              busy,
    output logic              map_led
);

    // Command-sequence states
    localparam logic [2:0] c_cmd0 = 3'd0;
    localparam logic [2:0] c_cmd1 = 3'd1;
    localparam logic [2:0] c_cmd2 = 3'd2;
    localparam logic [2:0] c_pgm  = 3'd3;
    localparam logic [2:0] c_er0  = 3'd4;
    localparam logic [2:0] c_er1  = 3'd5;
    localparam logic [2:0] c_er2  = 3'd6;

    // Execution states
    localparam logic [1:0] c_ex_idle = 2'd0;
    localparam logic [1:0] c_ex_prd  = 2'd1;
    localparam logic [1:0] c_ex_pwr  = 2'd2;
    localparam logic [1:0] c_ex_ers  = 2'd3;

    localparam logic [ADDR_W-1:0] c_one       = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] c_sect_last = {{(ADDR_W-SECT_W){1'b0}}, {SECT_W{1'b1}}};
    localparam logic [ADDR_W-1:0] c_chip_last = {ADDR_W{1'b1}};

    logic [2:0]        r_cmd_state;
    logic [2:0]        w_cmd_next;
    logic [1:0]        r_ex_state;
    logic [1:0]        w_ex_next;

    logic              r_mem_req;
    logic [ADDR_W-1:0] r_paddr;
    logic [7:0]        r_pdat;
    logic [7:0]        r_rdat;
    logic [ADDR_W-1:0] r_base;
    logic [ADDR_W-1:0] r_cnt;
    logic              r_chip;
    logic              r_id_mode;
    logic              r_toggle;

    logic              w_busy;
    logic              w_wr;
    logic              w_ack;
    logic              w_at_5555;
    logic              w_at_2aaa;
    logic              w_go_pgm;
    logic              w_go_sect;
    logic              w_go_chip;
    logic              w_id_set;
    logic              w_id_clr;
    logic [ADDR_W-1:0] w_last;

    // Command addresses only decode the low 15 bits, independent of bank
    assign w_at_5555 = (bus_addr[14:0] == 15'h5555);
    assign w_at_2aaa = (bus_addr[14:0] == 15'h2AAA);
    assign w_busy    = (r_ex_state != c_ex_idle);
    assign w_wr      = wr_stb & ~w_busy;
    assign w_ack     = mem_ack & r_mem_req;
    assign w_last    = r_chip ? c_chip_last : c_sect_last;

    assign mem_req   = r_mem_req;
    assign busy      = w_busy;
    assign map_led   = w_busy | r_id_mode | (r_cmd_state != c_cmd0);

    // ------------------------------------------------------------------
    // Command FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cmd_state <= c_cmd0;
        end else begin
            r_cmd_state <= w_cmd_next;
        end
    end

    // ------------------------------------------------------------------
    // Command FSM: next state and command decode
    // ------------------------------------------------------------------
    always_comb begin
        w_cmd_next = r_cmd_state;
        w_go_pgm   = 1'b0;
        w_go_sect  = 1'b0;
        w_go_chip  = 1'b0;
        w_id_set   = 1'b0;
        w_id_clr   = 1'b0;
        if (w_wr) begin
            w_cmd_next = c_cmd0;
            case (r_cmd_state)
                c_cmd0: begin
                    if (bus_dat == 8'hF0) begin
                        w_id_clr = 1'b1;
                    end else if (w_at_5555 && bus_dat == 8'hAA) begin
                        w_cmd_next = c_cmd1;
                    end
                end
                c_cmd1: begin
                    if (w_at_2aaa && bus_dat == 8'h55) begin
                        w_cmd_next = c_cmd2;
                    end
                end
                c_cmd2: begin
                    if (w_at_5555) begin
                        case (bus_dat)
                            8'hA0:   w_cmd_next = c_pgm;
                            8'h80:   w_cmd_next = c_er0;
                            8'h90:   w_id_set   = 1'b1;
                            8'hF0:   w_id_clr   = 1'b1;
                            default: w_cmd_next = c_cmd0;
                        endcase
                    end
                end
                c_pgm: begin
                    w_go_pgm = 1'b1;
                end
                c_er0: begin
                    if (w_at_5555 && bus_dat == 8'hAA) begin
                        w_cmd_next = c_er1;
                    end
                end
                c_er1: begin
                    if (w_at_2aaa && bus_dat == 8'h55) begin
                        w_cmd_next = c_er2;
                    end
                end
                c_er2: begin
                    if (bus_dat == 8'h30) begin
                        w_go_sect = 1'b1;
                    end else if (w_at_5555 && bus_dat == 8'h10) begin
                        w_go_chip = 1'b1;
                    end
                end
                default: w_cmd_next = c_cmd0;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Exec FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex_state <= c_ex_idle;
        end else begin
            r_ex_state <= w_ex_next;
        end
    end

    // ------------------------------------------------------------------
    // Exec FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        w_ex_next = r_ex_state;
        case (r_ex_state)
            c_ex_idle: begin
                if (w_go_pgm) begin
                    w_ex_next = c_ex_prd;
                end else if (w_go_sect || w_go_chip) begin
                    w_ex_next = c_ex_ers;
                end
            end
            c_ex_prd: begin
                if (w_ack) w_ex_next = c_ex_pwr;
            end
            c_ex_pwr: begin
                if (w_ack) w_ex_next = c_ex_idle;
            end
            c_ex_ers: begin
                if (w_ack && r_cnt == w_last) w_ex_next = c_ex_idle;
            end
            default: w_ex_next = c_ex_idle;
        endcase
    end

    // ------------------------------------------------------------------
    // Exec FSM: memory-port outputs (held constant per state, so they are
    // stable for the whole request)
    // ------------------------------------------------------------------
    always_comb begin
        mem_we   = 1'b0;
        mem_addr = '0;
        mem_wdat = 8'h00;
        case (r_ex_state)
            c_ex_prd: begin
                mem_addr = r_paddr;
            end
            c_ex_pwr: begin
                mem_we   = 1'b1;
                mem_addr = r_paddr;
                mem_wdat = r_rdat & r_pdat;  // flash program can only clear bits
            end
            c_ex_ers: begin
                mem_we   = 1'b1;
                mem_addr = r_base + r_cnt;
                mem_wdat = 8'hFF;
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Read override: status polling while busy, ID bytes in ID mode
    // ------------------------------------------------------------------
    always_comb begin
        rd_ovr = 1'b0;
        rd_dat = 8'h00;
        if (w_busy) begin
            rd_ovr    = 1'b1;
            rd_dat[7] = (r_ex_state == c_ex_ers) ? 1'b0 : ~r_pdat[7];
            rd_dat[6] = r_toggle;
        end else if (r_id_mode) begin
            rd_ovr = 1'b1;
            rd_dat = bus_addr[0] ? ID_DEV : ID_MFG;
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem_req <= 1'b0;
            r_paddr   <= '0;
            r_pdat    <= 8'h00;
            r_rdat    <= 8'h00;
            r_base    <= '0;
            r_cnt     <= '0;
            r_chip    <= 1'b0;
            r_id_mode <= 1'b0;
            r_toggle  <= 1'b0;
        end else begin
            if (w_go_pgm) begin
                r_paddr <= bus_addr;
                r_pdat  <= bus_dat;
            end

            if (w_go_sect || w_go_chip) begin
                r_base <= w_go_chip ? '0 : {bus_addr[ADDR_W-1:SECT_W], {SECT_W{1'b0}}};
                r_chip <= w_go_chip;
                r_cnt  <= '0;
            end else if (w_ack && r_ex_state == c_ex_ers) begin
                r_cnt  <= r_cnt + c_one;
            end

            if (w_ack && r_ex_state == c_ex_prd) begin
                r_rdat <= mem_rdat;
            end

            // Request rises one clock after entering an access state and
            // drops on the clock that sees the ack
            if (w_ack) begin
                r_mem_req <= 1'b0;
            end else if (r_ex_state != c_ex_idle) begin
                r_mem_req <= 1'b1;
            end

            if (w_id_set) begin
                r_id_mode <= 1'b1;
            end else if (w_id_clr) begin
                r_id_mode <= 1'b0;
            end

            if (w_ex_next == c_ex_idle) begin
                r_toggle <= 1'b0;
            end else if (rd_stb && w_busy) begin
                r_toggle <= ~r_toggle;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_map_030_flash_emu.sv
`default_nettype none
// ============================================================================
// Module   : tb_map_030_flash_emu
// Desc     : Directed self-checking bench for the mapper-30 flash emulator.
// Revision : 1.0 - initial release
// ============================================================================
module tb_map_030_flash_emu;

    localparam int ADDR_W = 19;

    logic              clk      = 1'b0;
    logic              rst_n    = 1'b0;
    logic              wr_stb   = 1'b0;
    logic              rd_stb   = 1'b0;
    logic [ADDR_W-1:0] bus_addr = '0;
    logic [7:0]        bus_dat  = 8'h00;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdat;
    logic              mem_ack  = 1'b0;
    logic [7:0]        mem_rdat = 8'h00;
    logic              rd_ovr;
    logic [7:0]        rd_dat;
    logic              busy;
    logic              map_led;

    map_030_flash_emu #(
        .ID_MFG (8'hBF),
        .ID_DEV (8'hB7),
        .ADDR_W (ADDR_W),
        .SECT_W (12)
    ) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_stb   (wr_stb),
        .rd_stb   (rd_stb),
        .bus_addr (bus_addr),
        .bus_dat  (bus_dat),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdat (mem_wdat),
        .mem_ack  (mem_ack),
        .mem_rdat (mem_rdat),
        .rd_ovr   (rd_ovr),
        .rd_dat   (rd_dat),
        .busy     (busy),
        .map_led  (map_led)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // PSRAM responder: acks after lat idle cycles, logs every completed access
    int                lat       = 0;
    int                lat_cnt   = 0;
    int                ack_total = 0;
    int                unstable  = 0;
    logic              holding   = 1'b0;
    logic [ADDR_W+8:0] held      = '0;
    logic [7:0]        rd_value  = 8'hF0;
    logic              log_we[$];
    logic [ADDR_W-1:0] log_addr[$];
    logic [7:0]        log_dat[$];

    always @(negedge clk) begin
        if (!rst_n) begin
            mem_ack = 1'b0;
            lat_cnt = 0;
            holding = 1'b0;
        end else if (mem_ack) begin
            mem_ack = 1'b0;
        end else if (mem_req) begin
            if (!holding) begin
                held    = {mem_we, mem_addr, mem_wdat};
                holding = 1'b1;
            end else if ({mem_we, mem_addr, mem_wdat} !== held) begin
                unstable++;
            end
            if (lat_cnt >= lat) begin
                mem_ack  = 1'b1;
                mem_rdat = rd_value;
                log_we.push_back(mem_we);
                log_addr.push_back(mem_addr);
                log_dat.push_back(mem_wdat);
                ack_total++;
                lat_cnt = 0;
                holding = 1'b0;
            end else begin
                lat_cnt++;
            end
        end
    end

    task automatic clear_log();
        log_we.delete();
        log_addr.delete();
        log_dat.delete();
    endtask

    task automatic cpu_write(input logic [ADDR_W-1:0] a, input logic [7:0] d);
        @(negedge clk);
        bus_addr = a;
        bus_dat  = d;
        wr_stb   = 1'b1;
        @(negedge clk);
        wr_stb   = 1'b0;
    endtask

    task automatic cpu_read(input logic [ADDR_W-1:0] a);
        @(negedge clk);
        bus_addr = a;
        rd_stb   = 1'b1;
        @(negedge clk);
        rd_stb   = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int n = 0;
        while (busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_val(tag, busy, 0);
    endtask

    task automatic check_zero(input string p);
        check_val({p, "_mem_req"},  mem_req,  0);
        check_val({p, "_mem_we"},   mem_we,   0);
        check_val({p, "_mem_addr"}, mem_addr, 0);
        check_val({p, "_mem_wdat"}, mem_wdat, 0);
        check_val({p, "_rd_ovr"},   rd_ovr,   0);
        check_val({p, "_rd_dat"},   rd_dat,   0);
        check_val({p, "_busy"},     busy,     0);
        check_val({p, "_map_led"},  map_led,  0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int                bad;
        int                n;
        int                base_acks;
        logic [ADDR_W-1:0] ea;

        // Reset
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_zero("rst");
        rst_n = 1'b1;
        @(negedge clk);

        // Byte program 0x3C into 0xF0 -> 0x30
        clear_log();
        lat      = 8;
        rd_value = 8'hF0;
        cpu_write(19'h05555, 8'hAA);
        check_val("pgm_led_seq", map_led, 1);
        cpu_write(19'h02AAA, 8'h55);
        cpu_write(19'h05555, 8'hA0);
        cpu_write(19'h12345, 8'h3C);
        check_val("pgm_busy", busy, 1);
        cpu_read(19'h12345);
        check_val("poll_ovr", rd_ovr, 1);
        check_val("poll1", rd_dat, 8'hC0);
        cpu_read(19'h12345);
        check_val("poll2", rd_dat, 8'h80);
        cpu_read(19'h12345);
        check_val("poll3", rd_dat, 8'hC0);
        wait_idle(200, "pgm_done");
        check_val("pgm_nacc", log_we.size(), 2);
        if (log_we.size() >= 2) begin
            check_val("pgm_rd_we",   log_we[0],   0);
            check_val("pgm_rd_addr", log_addr[0], 19'h12345);
            check_val("pgm_wr_we",   log_we[1],   1);
            check_val("pgm_wr_addr", log_addr[1], 19'h12345);
            check_val("pgm_wr_dat",  log_dat[1],  8'h30);
        end
        cpu_read(19'h12345);
        check_val("pgm_ovr_after", rd_ovr, 0);
        check_val("pgm_led_after", map_led, 0);

        // Sector erase of 0x2A000..0x2AFFF, with an ignored write mid-erase
        clear_log();
        lat      = 0;
        rd_value = 8'h00;
        cpu_write(19'h05555, 8'hAA);
        cpu_write(19'h02AAA, 8'h55);
        cpu_write(19'h05555, 8'h80);
        cpu_write(19'h05555, 8'hAA);
        cpu_write(19'h02AAA, 8'h55);
        cpu_write(19'h2A7FF, 8'h30);
        check_val("ers_busy", busy, 1);
        check_val("ers_ovr", rd_ovr, 1);
        check_val("ers_status", rd_dat, 8'h00);
        cpu_write(19'h05555, 8'hAA);
        wait_idle(20000, "ers_done");
        check_val("ers_ignored_wr", map_led, 0);
        check_val("ers_count", log_we.size(), 4096);
        bad = 0;
        for (int i = 0; i < log_we.size(); i++) begin
            ea = 19'h2A000 + ADDR_W'(i);
            if (log_we[i] !== 1'b1 || log_addr[i] !== ea || log_dat[i] !== 8'hFF) bad++;
        end
        check_val("ers_seq", bad, 0);
        check_val("req_stable", unstable, 0);

        // Software ID
        clear_log();
        cpu_write(19'h05555, 8'hAA);
        cpu_write(19'h02AAA, 8'h55);
        cpu_write(19'h05555, 8'h90);
        check_val("id_led", map_led, 1);
        check_val("id_busy", busy, 0);
        cpu_read(19'h00000);
        check_val("id_ovr", rd_ovr, 1);
        check_val("id_mfg", rd_dat, 8'hBF);
        cpu_read(19'h00001);
        check_val("id_dev", rd_dat, 8'hB7);
        cpu_write(19'h00000, 8'hF0);
        check_val("id_exit_ovr", rd_ovr, 0);
        check_val("id_exit_led", map_led, 0);
        check_val("id_nacc", log_we.size(), 0);

        // Broken sequence
        cpu_write(19'h05555, 8'hAA);
        check_val("brk_led1", map_led, 1);
        cpu_write(19'h02AAA, 8'h56);
        check_val("brk_led2", map_led, 0);
        cpu_write(19'h04000, 8'h00);
        repeat (5) @(negedge clk);
        check_val("brk_busy", busy, 0);
        check_val("brk_req", mem_req, 0);
        check_val("brk_nacc", log_we.size(), 0);

        // Chip erase aborted by reset after 100 acks
        clear_log();
        lat = 0;
        cpu_write(19'h05555, 8'hAA);
        cpu_write(19'h02AAA, 8'h55);
        cpu_write(19'h05555, 8'h80);
        cpu_write(19'h05555, 8'hAA);
        cpu_write(19'h02AAA, 8'h55);
        cpu_write(19'h05555, 8'h10);
        check_val("ce_busy", busy, 1);
        base_acks = ack_total;
        n = 0;
        while (!((ack_total - base_acks) >= 100 && mem_req) && n < 2000) begin
            @(posedge clk);
            #2;
            n++;
        end
        check_val("ce_reached", (n < 2000), 1);
        rst_n = 1'b0;
        #1;
        check_val("ce_async_req", mem_req, 0);
        check_val("ce_async_busy", busy, 0);
        check_val("ce_count", log_we.size(), 100);
        bad = 0;
        for (int i = 0; i < log_we.size(); i++) begin
            ea = ADDR_W'(i);
            if (log_we[i] !== 1'b1 || log_addr[i] !== ea || log_dat[i] !== 8'hFF) bad++;
        end
        check_val("ce_seq", bad, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        bus_addr = '0;
        #1;
        check_zero("post");
        repeat (5) @(negedge clk);
        check_val("post_idle_req", mem_req, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
